booth_seq_multiplier: RTL and testbench
=======================================

// Module: booth_seq_multiplier
// PURPOSE
//   Multi-cycle signed 32x32 multiplier for the execute stage, alongside the ALU shift path.
//   Uses radix-2 Booth recoding: add/subtract the multiplicand, then arithmetic-shift right by 1 each step.
//   Takes a start pulse from decode and returns a WIDTH-bit result with overflow and ready flags.
//   Writeback stalls on busy and consumes data_result when data_resultRDY is high.
// PARAMETERS
//   WIDTH   32   operand/result width; product register is 2*WIDTH+1 bits, accumulator WIDTH+1 bits
// PORTS
//   clock           in   1      single clock, rising edge
//   reset           in   1      synchronous, active-high
//   ctrl_MULT       in   1      start pulse; operands sampled on the same edge
//   data_operandA   in   WIDTH  multiplicand, two's complement
//   data_operandB   in   WIDTH  multiplier, two's complement
//   data_result     out  WIDTH  low WIDTH bits of product
//   data_exception  out  1      signed overflow: product does not fit in WIDTH bits
//   data_resultRDY  out  1      one-cycle pulse, result valid
//   busy            out  1      high in RUN state
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, counter=0, product reg=0, data_result=0, data_exception=0,
//     data_resultRDY=0, busy=0. Reset mid-RUN aborts; no RDY pulse is produced for the aborted op.
//   States: IDLE, RUN, DONE.
//     IDLE: ctrl_MULT=1 at edge E0 -> load A (sign-extended to WIDTH+1), P={0,B,1'b0}, counter=0 -> RUN.
//     RUN: each edge performs one Booth step on P[1:0]:
//       01 -> upper += A; 10 -> upper -= A; 00/11 -> no change; then arithmetic shift P right by 1.
//       counter increments per step; after step WIDTH (edge E_WIDTH) -> DONE. ctrl_MULT ignored in RUN.
//     DONE: data_resultRDY=1 for exactly this one cycle (WIDTH cycles after E0 sample).
//       Next edge: ctrl_MULT=1 -> reload, go to RUN (back-to-back); else -> IDLE.
//   Result: prod = P[2*WIDTH:1] (2*WIDTH bits). data_result = prod[WIDTH-1:0].
//     data_exception = 1 iff prod[2*WIDTH-1:WIDTH-1] not all equal.
//     Both outputs register at the RUN->DONE edge and hold until the next RUN->DONE edge or reset.
//     They do not change during a later RUN.
//   Accumulator is WIDTH+1 bits so that subtracting A = -2^(WIDTH-1) cannot wrap.
//   Operand changes after E0 have no effect. A or B = 0 still takes the full WIDTH steps.
//   busy = (state==RUN); busy and data_resultRDY are never high together.
// TESTING
//   A=3, B=5, pulse ctrl_MULT -> busy 32 cycles, RDY pulse 1 cycle, result=15, exception=0.
//   A=-7, B=6 -> result=0xFFFFFFD6 (-42), exception=0. A=0x7FFFFFFF, B=-1 -> 0x80000001, exc=0.
//   A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1 (true product +2^31).
//   A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1.
//   Start, assert reset at cycle 10 of RUN -> next cycle all outputs 0, state IDLE; no RDY pulse.
//     A new start then yields a correct result.
//   Re-pulse ctrl_MULT mid-RUN with other operands -> ignored, original result returned.
//     Pulse again during the DONE cycle -> second op starts, RDY again 32 cycles later.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier
//   Multi-cycle signed WIDTH x WIDTH multiplier using radix-2 Booth recoding.
//   In each RUN cycle the multiplicand is added to or subtracted from the upper half of the
//   product register. The register is then shifted right arithmetically by one bit.
//   After WIDTH steps the low WIDTH bits of the product are registered with an overflow flag.
// Ports
//   clock          : rising-edge clock
//   reset          : synchronous, active-high
//   ctrl_MULT      : start pulse; the operands are sampled on the same edge (ignored in RUN)
//   data_operandA  : multiplicand, two's complement
//   data_operandB  : multiplier, two's complement
//   data_result    : low WIDTH bits of the product, held until the next completion
//   data_exception : product does not fit in WIDTH signed bits
//   data_resultRDY : one-cycle pulse, result valid
//   busy           : multiplication in progress
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic [PW-1:0]     prod_q;
  logic [WIDTH:0]    mcand_q;

  logic [WIDTH:0]    upper_ext;
  logic [WIDTH:0]    acc;
  logic [PW-1:0]     prod_step;
  logic [2*WIDTH-1:0] prod_full;
  logic [WIDTH:0]    sign_win;
  logic              last_step;

  // One Booth step. The accumulator is WIDTH+1 bits wide, so subtracting the most
  // negative multiplicand cannot wrap. Its MSB is the true sign that is shifted in.
  always_comb begin
    upper_ext = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
    case (prod_q[1:0])
      2'b01:   acc = upper_ext + mcand_q;
      2'b10:   acc = upper_ext - mcand_q;
      default: acc = upper_ext;
    endcase
    prod_step = {acc, prod_q[WIDTH:1]};
    prod_full = prod_step[PW-1:1];
    // Every bit from WIDTH-1 upward must match the sign for the product to fit.
    sign_win  = prod_full[2*WIDTH-1:WIDTH-1];
    last_step = (count_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      count_q        <= '0;
      prod_q         <= '0;
      mcand_q        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (ctrl_MULT) begin
            mcand_q <= {data_operandA[WIDTH-1], data_operandA};
            prod_q  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            count_q <= '0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          prod_q  <= prod_step;
          count_q <= count_q + CW'(1);
          if (last_step) begin
            state_q        <= StDone;
            data_result    <= prod_full[WIDTH-1:0];
            data_exception <= ~((&sign_win) | ~(|sign_win));
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy           = (state_q == StRun);
  assign data_resultRDY = (state_q == StDone);

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;

  booth_seq_multiplier #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Pulse ctrl_MULT for one rising edge. Afterwards the operands are scrambled.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
  endtask

  // Wait at negedges for RDY. The wait is bounded by a cycle budget.
  task automatic wait_rdy(output int busy_cycles, output bit seen, output bit overlap);
    busy_cycles = 0;
    seen        = 1'b0;
    overlap     = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (busy && data_resultRDY) overlap = 1'b1;
      if (data_resultRDY) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (data_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got=%h exp=%h", data_result, 32'h0);
    end
    checks++;
    if (data_exception !== 1'b0) begin
      errors++;
      $display("FAIL reset_exception got=%b exp=0", data_exception);
    end
    checks++;
    if (data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy got=%b exp=0", data_resultRDY);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  task automatic test_products();
    vec_t vecs[9];
    int   cyc;
    bit   seen;
    bit   ovl;
    vecs[0] = '{32'd3,         32'd5,         32'd15,        1'b0};
    vecs[1] = '{32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0,         32'h1234_5678, 32'h0000_0000, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[8] = '{32'hFFFF_8000, 32'h0001_0000, 32'h8000_0000, 1'b0};
    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_rdy(cyc, seen, ovl);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL prod%0d_rdy_timeout got=no_rdy exp=rdy", i);
      end
      checks++;
      if (cyc != 32) begin
        errors++;
        $display("FAIL prod%0d_busy_cycles got=%0d exp=32", i, cyc);
      end
      checks++;
      if (ovl) begin
        errors++;
        $display("FAIL prod%0d_busy_rdy_overlap got=1 exp=0", i);
      end
      checks++;
      if (data_result !== vecs[i].res) begin
        errors++;
        $display("FAIL prod%0d_result got=%h exp=%h", i, data_result, vecs[i].res);
      end
      checks++;
      if (data_exception !== vecs[i].exc) begin
        errors++;
        $display("FAIL prod%0d_exception got=%b exp=%b", i, data_exception, vecs[i].exc);
      end
      @(negedge clock);
      checks++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL prod%0d_after_pulse got=rdy%b_busy%b exp=rdy0_busy0", i,
                 data_resultRDY, busy);
      end
      checks++;
      if (data_result !== vecs[i].res) begin
        errors++;
        $display("FAIL prod%0d_hold got=%h exp=%h", i, data_result, vecs[i].res);
      end
    end
  endtask

  task automatic test_abort();
    int  cyc;
    bit  seen;
    bit  ovl;
    bit  rdy_seen = 1'b0;
    // The previous result is nonzero, so a reset to zero can be observed.
    start_op(32'd3, 32'd5);
    wait_rdy(cyc, seen, ovl);
    start_op(32'd100, 32'd200);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL abort_outputs got=%h/%b exp=00000000/0", data_result, data_exception);
    end
    checks++;
    if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got=busy%b_rdy%b exp=busy0_rdy0", busy, data_resultRDY);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY || busy) rdy_seen = 1'b1;
    end
    checks++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL abort_no_rdy got=activity exp=none");
    end
    start_op(32'hFFFF_FFFD, 32'hFFFF_FFFB);
    wait_rdy(cyc, seen, ovl);
    checks++;
    if (!seen || cyc != 32 || data_result !== 32'd15 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart got=seen%b_cyc%0d_%h_%b exp=seen1_cyc32_0000000f_0",
               seen, cyc, data_result, data_exception);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    bit ovl;
    start_op(32'd3, 32'd5);
    repeat (5) @(negedge clock);
    // A pulse during RUN with other operands must be ignored.
    data_operandA = 32'd100;
    data_operandB = 32'd100;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    wait_rdy(cyc, seen, ovl);
    checks++;
    if (!seen || cyc != 27 || data_result !== 32'd15) begin
      errors++;
      $display("FAIL ignore_midrun got=seen%b_cyc%0d_%h exp=seen1_cyc27_0000000f",
               seen, cyc, data_result);
    end
    // We are now in the DONE cycle, so a start here begins the next op immediately.
    data_operandA = 32'hFFFF_FFF9;
    data_operandB = 32'd6;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'h0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || data_result !== 32'd15) begin
      errors++;
      $display("FAIL b2b_start got=busy%b_%h exp=busy1_0000000f", busy, data_result);
    end
    wait_rdy(cyc, seen, ovl);
    checks++;
    if (!seen || cyc != 31 || ovl) begin
      errors++;
      $display("FAIL b2b_latency got=seen%b_cyc%0d_ovl%b exp=seen1_cyc31_ovl0", seen, cyc, ovl);
    end
    checks++;
    if (data_result !== 32'hFFFF_FFD6 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL b2b_result got=%h/%b exp=ffffffd6/0", data_result, data_exception);
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
